// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin sharing of one single-port synchronous memory between fetch and load/store.
module mem_port_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic              i_CLK,
  input  logic              i_RST,
  input  logic              i_IF_REQ,
  input  logic [ADDR_W-1:0] i_IF_ADDR,
  output logic              o_IF_GNT,
  output logic              o_IF_VALID,
  output logic [DATA_W-1:0] o_IF_DATA,
  input  logic              i_DM_REQ,
  input  logic              i_DM_WE,
  input  logic [ADDR_W-1:0] i_DM_ADDR,
  input  logic [DATA_W-1:0] i_DM_WDATA,
  output logic              o_DM_GNT,
  output logic              o_DM_VALID,
  output logic [DATA_W-1:0] o_DM_RDATA,
  output logic              o_MEM_EN,
  output logic              o_MEM_WE,
  output logic [ADDR_W-1:0] o_MEM_ADDR,
  output logic [DATA_W-1:0] o_MEM_WDATA,
  input  logic [DATA_W-1:0] i_MEM_RDATA,
  output logic              o_BUSY
);
  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE} state_t;
  state_t            state_q, state_d;
  logic              lw_q, lw_d, win_q, win_d, we_q, we_d;
  logic              if_valid_q, if_valid_d, dm_valid_q, dm_valid_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, if_data_q, if_data_d, dm_rdata_q, dm_rdata_d;
  logic              pick_dm;
  // Under contention the side that did not win last time goes first.
  assign pick_dm = i_DM_REQ & (~i_IF_REQ | ~lw_q);
  always_comb begin
    state_d    = state_q;
    lw_d       = lw_q;
    win_d      = win_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    if_data_d  = if_data_q;
    dm_rdata_d = dm_rdata_q;
    if_valid_d = 1'b0;
    dm_valid_d = 1'b0;
    case (state_q)
      IDLE: if (i_IF_REQ | i_DM_REQ) begin
        state_d = ISSUE;
        lw_d    = pick_dm;
        win_d   = pick_dm;
        we_d    = pick_dm & i_DM_WE;
        addr_d  = pick_dm ? i_DM_ADDR : i_IF_ADDR;
        wdata_d = pick_dm ? i_DM_WDATA : wdata_q;
      end
      ISSUE: state_d = we_q ? IDLE : CAPTURE;
      CAPTURE: begin
        state_d    = IDLE;
        if_data_d  = win_q ? if_data_q : i_MEM_RDATA;
        dm_rdata_d = win_q ? i_MEM_RDATA : dm_rdata_q;
        if_valid_d = ~win_q;
        dm_valid_d = win_q;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge i_CLK) begin
    if (!i_RST) begin
      state_q    <= IDLE;
      lw_q       <= 1'b0;
      win_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      if_data_q  <= '0;
      dm_rdata_q <= '0;
      if_valid_q <= 1'b0;
      dm_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      lw_q       <= lw_d;
      win_q      <= win_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      if_data_q  <= if_data_d;
      dm_rdata_q <= dm_rdata_d;
      if_valid_q <= if_valid_d;
      dm_valid_q <= dm_valid_d;
    end
  end
  assign o_MEM_EN    = state_q == ISSUE;
  assign o_MEM_WE    = o_MEM_EN & we_q;
  assign o_MEM_ADDR  = addr_q;
  assign o_MEM_WDATA = wdata_q;
  assign o_IF_GNT    = o_MEM_EN & ~win_q;
  assign o_DM_GNT    = o_MEM_EN & win_q;
  assign o_IF_VALID  = if_valid_q;
  assign o_DM_VALID  = dm_valid_q;
  assign o_IF_DATA   = if_data_q;
  assign o_DM_RDATA  = dm_rdata_q;
  assign o_BUSY      = state_q != IDLE;
endmodule
